bcd_stopwatch: RTL and testbench

BCD_STOPWATCH -- requirements
Module: bcd_stopwatch

---
 rtl/bcd_stopwatch_pkg.sv | 17 +
 rtl/bcd_stopwatch_if.sv | 27 ++
 rtl/bcd_stopwatch_seg7.sv | 26 ++
 rtl/bcd_stopwatch.sv | 167 ++++++++++++++++
 tb/tb_bcd_stopwatch.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/bcd_stopwatch_pkg.sv
// Shared definitions for the BCD stopwatch: FSM encoding, BCD digit limits
// and the fixed segment codes used at reset and for non-decimal inputs.
package bcd_stopwatch_pkg;

    typedef enum logic {
        STOP = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [3:0] ONES_MAX = 4'd9;
    localparam logic [3:0] TENS_MAX = 4'd5;

    // Segment bit 6 drives segment a and bit 0 drives segment g; all active-low.
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ZERO  = 7'b0000001;

endpackage

// File: rtl/bcd_stopwatch_if.sv
// Control inputs and time/display outputs of the stopwatch bundled as one port.
interface bcd_stopwatch_if;

    logic       tick_in;
    logic       start_stop;
    logic       clear;
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       running;
    logic       wrap;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    modport master (
        output tick_in, start_stop, clear,
        input  min_tens, min_ones, sec_tens, sec_ones, running, wrap, an, seg, dp
    );

    modport slave (
        input  tick_in, start_stop, clear,
        output min_tens, min_ones, sec_tens, sec_ones, running, wrap, an, seg, dp
    );

endinterface

// File: rtl/bcd_stopwatch_seg7.sv
// Combinational BCD to active-low 7-segment decoder; codes 10-15 are blanked.
module seg7_decode
    import bcd_stopwatch_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0: seg = SEG_ZERO;
            4'd1: seg = 7'b1001111;
            4'd2: seg = 7'b0010010;
            4'd3: seg = 7'b0000110;
            4'd4: seg = 7'b1001100;
            4'd5: seg = 7'b0100100;
            4'd6: seg = 7'b0100000;
            4'd7: seg = 7'b0001111;
            4'd8: seg = 7'b0000000;
            4'd9: seg = 7'b0000100;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/bcd_stopwatch.sv
// MM:SS BCD stopwatch counting 1 Hz ticks, with start/stop, clear and a
// multiplexed four-digit 7-segment display scan.
module bcd_stopwatch
    import bcd_stopwatch_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic            clkin,
    input  logic            rstn,
    bcd_stopwatch_if.slave  bus
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic             tick_q;
    logic             ss_q;
    logic             tick_pulse;
    logic             ss_pulse;
    state_t           state;
    state_t           state_next;
    logic [3:0]       sec_ones;
    logic [3:0]       sec_tens;
    logic [3:0]       min_ones;
    logic [3:0]       min_tens;
    logic [3:0]       sec_ones_next;
    logic [3:0]       sec_tens_next;
    logic [3:0]       min_ones_next;
    logic [3:0]       min_tens_next;
    logic             wrap;
    logic             wrap_next;
    logic [CNT_W-1:0] scan_cnt;
    logic [1:0]       digit_idx;
    logic [3:0]       sel_digit;
    logic [6:0]       seg_dec;
    logic [3:0]       an;
    logic [6:0]       seg;
    logic             dp;

    // Edge detectors reset high so an input already high at release is not an edge.
    always_ff @(posedge clkin or negedge rstn) begin
        if (!rstn) begin
            tick_q <= 1'b1;
            ss_q   <= 1'b1;
        end else begin
            tick_q <= bus.tick_in;
            ss_q   <= bus.start_stop;
        end
    end

    assign tick_pulse = bus.tick_in & ~tick_q;
    assign ss_pulse   = bus.start_stop & ~ss_q;

    always_ff @(posedge clkin or negedge rstn) begin
        if (!rstn) begin
            state    <= STOP;
            sec_ones <= 4'd0;
            sec_tens <= 4'd0;
            min_ones <= 4'd0;
            min_tens <= 4'd0;
            wrap     <= 1'b0;
        end else begin
            state    <= state_next;
            sec_ones <= sec_ones_next;
            sec_tens <= sec_tens_next;
            min_ones <= min_ones_next;
            min_tens <= min_tens_next;
            wrap     <= wrap_next;
        end
    end

    // The tick is judged against the current state, so a coincident toggle
    // only affects ticks from the following cycle on.
    always_comb begin
        state_next    = state;
        sec_ones_next = sec_ones;
        sec_tens_next = sec_tens;
        min_ones_next = min_ones;
        min_tens_next = min_tens;
        wrap_next     = 1'b0;
        if (bus.clear) begin
            state_next    = STOP;
            sec_ones_next = 4'd0;
            sec_tens_next = 4'd0;
            min_ones_next = 4'd0;
            min_tens_next = 4'd0;
        end else begin
            if (state == RUN && tick_pulse) begin
                if (sec_ones == ONES_MAX) begin
                    sec_ones_next = 4'd0;
                    if (sec_tens == TENS_MAX) begin
                        sec_tens_next = 4'd0;
                        if (min_ones == ONES_MAX) begin
                            min_ones_next = 4'd0;
                            if (min_tens == TENS_MAX) begin
                                min_tens_next = 4'd0;
                                wrap_next     = 1'b1;
                            end else begin
                                min_tens_next = min_tens + 4'd1;
                            end
                        end else begin
                            min_ones_next = min_ones + 4'd1;
                        end
                    end else begin
                        sec_tens_next = sec_tens + 4'd1;
                    end
                end else begin
                    sec_ones_next = sec_ones + 4'd1;
                end
            end
            if (ss_pulse) begin
                state_next = (state == RUN) ? STOP : RUN;
            end
        end
    end

    always_ff @(posedge clkin or negedge rstn) begin
        if (!rstn) begin
            scan_cnt  <= '0;
            digit_idx <= 2'd0;
        end else if (scan_cnt == CNT_W'(SCAN_DIV - 1)) begin
            scan_cnt  <= '0;
            digit_idx <= digit_idx + 2'd1;
        end else begin
            scan_cnt  <= scan_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        sel_digit = sec_ones;
        case (digit_idx)
            2'd0: sel_digit = sec_ones;
            2'd1: sel_digit = sec_tens;
            2'd2: sel_digit = min_ones;
            2'd3: sel_digit = min_tens;
            default: sel_digit = sec_ones;
        endcase
    end

    seg7_decode u_seg7_decode (
        .bcd (sel_digit),
        .seg (seg_dec)
    );

    // Anode, segments and decimal point are registered together so they stay aligned.
    always_ff @(posedge clkin or negedge rstn) begin
        if (!rstn) begin
            an  <= 4'b1110;
            seg <= SEG_ZERO;
            dp  <= 1'b1;
        end else begin
            an  <= ~(4'b0001 << digit_idx);
            seg <= seg_dec;
            dp  <= (digit_idx != 2'd2);
        end
    end

    assign bus.sec_ones = sec_ones;
    assign bus.sec_tens = sec_tens;
    assign bus.min_ones = min_ones;
    assign bus.min_tens = min_tens;
    assign bus.running  = (state == RUN);
    assign bus.wrap     = wrap;
    assign bus.an       = an;
    assign bus.seg      = seg;
    assign bus.dp       = dp;

endmodule

// File: tb/tb_bcd_stopwatch.sv
// Randomized bench for bcd_stopwatch against a seconds-count reference model.
module tb_bcd_stopwatch;

    localparam int SCAN_DIV = 4;

    logic clkin = 1'b0;
    logic rstn;
    int   checks = 0;
    int   errors = 0;

    int         m_secs;
    int         m_cyc;
    bit         m_run;
    bit         m_wrap;
    bit         m_prev_tick;
    bit         m_prev_ss;
    logic [3:0] m_an;
    logic [6:0] m_seg;
    logic       m_dp;

    bcd_stopwatch_if bus ();

    bcd_stopwatch #(.SCAN_DIV(SCAN_DIV)) dut (
        .clkin (clkin),
        .rstn  (rstn),
        .bus   (bus)
    );

    always #5 clkin = ~clkin;

    function automatic logic [6:0] seg_code(input int d);
        case (d)
            0: return 7'b0000001;
            1: return 7'b1001111;
            2: return 7'b0010010;
            3: return 7'b0000110;
            4: return 7'b1001100;
            5: return 7'b0100100;
            6: return 7'b0100000;
            7: return 7'b0001111;
            8: return 7'b0000000;
            9: return 7'b0000100;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic int digit_of(input int secs, input int idx);
        case (idx)
            0: return secs % 10;
            1: return (secs % 60) / 10;
            2: return (secs / 60) % 10;
            default: return secs / 600;
        endcase
    endfunction

    function automatic logic [15:0] time_bcd(input int secs);
        return {4'(digit_of(secs, 3)), 4'(digit_of(secs, 2)),
                4'(digit_of(secs, 1)), 4'(digit_of(secs, 0))};
    endfunction

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_secs      = 0;
        m_cyc       = 0;
        m_run       = 1'b0;
        m_wrap      = 1'b0;
        m_prev_tick = 1'b1;
        m_prev_ss   = 1'b1;
        m_an        = 4'b1110;
        m_seg       = 7'b0000001;
        m_dp        = 1'b1;
    endtask

    // One clock edge of the reference: display shows the slot selected before the edge.
    task automatic model_edge();
        int  idx;
        bit  tp;
        bit  sp;
        if (!rstn) begin
            model_reset();
            return;
        end
        idx   = (m_cyc / SCAN_DIV) % 4;
        m_an  = 4'b1111;
        m_an[idx] = 1'b0;
        m_seg = seg_code(digit_of(m_secs, idx));
        m_dp  = (idx != 2);
        m_cyc++;
        tp     = bus.tick_in && !m_prev_tick;
        sp     = bus.start_stop && !m_prev_ss;
        m_wrap = 1'b0;
        if (bus.clear) begin
            m_secs = 0;
            m_run  = 1'b0;
        end else begin
            if (m_run && tp) begin
                if (m_secs == 3599) begin
                    m_secs = 0;
                    m_wrap = 1'b1;
                end else begin
                    m_secs++;
                end
            end
            if (sp) m_run = !m_run;
        end
        m_prev_tick = bus.tick_in;
        m_prev_ss   = bus.start_stop;
    endtask

    task automatic step();
        @(posedge clkin);
        model_edge();
        @(negedge clkin);
        check_output("cycle",
            {2'b0, bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones,
             bus.running, bus.wrap, bus.an, bus.seg, bus.dp},
            {2'b0, time_bcd(m_secs), m_run, m_wrap, m_an, m_seg, m_dp});
    endtask

    task automatic apply_stimulus(input bit tick, input bit ss, input bit clr);
        bus.tick_in    = tick;
        bus.start_stop = ss;
        bus.clear      = clr;
        step();
    endtask

    task automatic press();
        apply_stimulus(1'b0, 1'b1, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(1, 2)) apply_stimulus(1'b1, 1'b0, 1'b0);
            repeat ($urandom_range(1, 2)) apply_stimulus(1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic check_time(input string tag, input int secs);
        check_output(tag, {16'b0, bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones},
                     {16'b0, time_bcd(secs)});
    endtask

    task automatic check_reset_outputs(input string tag);
        check_time({tag, "_time"}, 0);
        check_output({tag, "_running"}, 32'(bus.running), 32'd0);
        check_output({tag, "_wrap"}, 32'(bus.wrap), 32'd0);
        check_output({tag, "_an"}, 32'(bus.an), 32'h0000000e);
        check_output({tag, "_seg"}, 32'(bus.seg), 32'h00000001);
        check_output({tag, "_dp"}, 32'(bus.dp), 32'd1);
    endtask

    initial begin
        int wrap_cnt;
        logic [3:0] scan_an [4];
        int         scan_dig [4];
        scan_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        scan_dig = '{4, 3, 2, 1};

        rstn           = 1'b0;
        bus.tick_in    = 1'b0;
        bus.start_stop = 1'b0;
        bus.clear      = 1'b0;
        model_reset();
        step();
        step();
        check_reset_outputs("reset");
        rstn = 1'b1;
        step();

        press();
        tick_n(3);
        check_time("count3", 3);
        check_output("count3_running", 32'(bus.running), 32'd1);

        tick_n(2);
        press();
        tick_n(4);
        check_time("hold", 5);
        check_output("hold_running", 32'(bus.running), 32'd0);

        apply_stimulus(1'b0, 1'b0, 1'b1);
        apply_stimulus(1'b0, 1'b0, 1'b0);
        press();
        tick_n(3598);
        check_time("preload", 3598);
        tick_n(1);
        check_time("last", 3599);
        wrap_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b1, 1'b0, 1'b0);
            wrap_cnt += int'(bus.wrap);
        end
        apply_stimulus(1'b0, 1'b0, 1'b0);
        check_output("wrap_once", 32'(wrap_cnt), 32'd1);
        check_time("wrap_time", 0);
        check_output("wrap_running", 32'(bus.running), 32'd1);

        tick_n(69);
        check_time("prio_pre", 69);
        apply_stimulus(1'b1, 1'b1, 1'b1);
        check_time("prio_time", 0);
        check_output("prio_running", 32'(bus.running), 32'd0);
        check_output("prio_wrap", 32'(bus.wrap), 32'd0);
        apply_stimulus(1'b0, 1'b0, 1'b0);

        press();
        tick_n(754);
        press();
        check_time("scan_time", 754);
        for (int i = 0; i < 8 && bus.an !== 4'b1110; i++) apply_stimulus(1'b0, 1'b0, 1'b0);
        check_output("scan_sync", 32'(bus.an), 32'h0000000e);
        for (int k = 0; k < 4; k++) begin
            check_output("scan_an", 32'(bus.an), 32'(scan_an[k]));
            check_output("scan_seg", 32'(bus.seg), 32'(seg_code(scan_dig[k])));
            check_output("scan_dp", 32'(bus.dp), (k == 2) ? 32'd0 : 32'd1);
            repeat (SCAN_DIV) apply_stimulus(1'b0, 1'b0, 1'b0);
        end

        apply_stimulus(1'b0, 1'b0, 1'b1);
        apply_stimulus(1'b0, 1'b0, 1'b0);
        press();
        tick_n(462);
        check_time("async_pre", 462);
        @(posedge clkin);
        model_edge();
        #2;
        rstn        = 1'b0;
        bus.tick_in = 1'b1;
        model_reset();
        #1;
        check_reset_outputs("async");
        @(negedge clkin);
        step();
        rstn = 1'b1;
        apply_stimulus(1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b1, 1'b0);
        apply_stimulus(1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b0, 1'b0);
        check_time("release_time", 0);
        check_output("release_running", 32'(bus.running), 32'd1);
        apply_stimulus(1'b0, 1'b0, 1'b0);
        tick_n(1);
        check_time("release_tick", 1);

        for (int i = 0; i < 400; i++) begin
            apply_stimulus(1'($urandom_range(0, 1)),
                           1'($urandom_range(0, 3) == 0),
                           1'($urandom_range(0, 31) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
